// File: rtl/rgmii_idelay_calibrator_pkg.sv
// Shared definitions for the RGMII receive IDELAY calibrator: tap width,
// sequencer states and the helper that picks the centre of a passing run.
package rgmii_idelay_pkg;

   localparam int TAP_BITS = 5;

   typedef enum logic [2:0] {
      WAIT_RDY,
      LOAD,
      SETTLE,
      MEASURE,
      EVAL,
      APPLY,
      DONE
   } calState_t;

   // Centre of a run of passing taps, rounded down. The caller guarantees
   // runLength is non-zero.
   function automatic int unsigned centreTap(input int unsigned runStart,
                                             input int unsigned runLength);
      return runStart + ((runLength - 1) >> 1);
   endfunction

endpackage

// File: rtl/rgmii_idelay_calibrator_if.sv
// Signal bundle between the calibrator and the IDELAYE2 / RX-path side.
// The master modport is the calibrator itself; the slave modport is the
// surrounding logic that supplies ready/start/good/bad and consumes the taps.
interface rgmii_idelay_calibrator_if
   import rgmii_idelay_pkg::*;
#(
   parameter int TAP_BITS = rgmii_idelay_pkg::TAP_BITS
);

   logic                io_idelayctrl_ready;
   logic                io_start;
   logic                io_good;
   logic                io_bad;
   logic [TAP_BITS-1:0] io_tap_value;
   logic                io_tap_load;
   logic                io_busy;
   logic                io_done;
   logic                io_fail;
   logic [TAP_BITS-1:0] io_best_start;
   logic [TAP_BITS:0]   io_best_length;

   modport master (
      input  io_idelayctrl_ready,
      input  io_start,
      input  io_good,
      input  io_bad,
      output io_tap_value,
      output io_tap_load,
      output io_busy,
      output io_done,
      output io_fail,
      output io_best_start,
      output io_best_length
   );

   modport slave (
      output io_idelayctrl_ready,
      output io_start,
      output io_good,
      output io_bad,
      input  io_tap_value,
      input  io_tap_load,
      input  io_busy,
      input  io_done,
      input  io_fail,
      input  io_best_start,
      input  io_best_length
   );

endinterface

// File: rtl/rgmii_idelay_calibrator_eye_tracker.sv
// Longest-passing-run tracker. Fed one pass/fail verdict per tap in
// ascending tap order; remembers the earliest longest run of consecutive
// passes. Runs never wrap from the top tap back to tap 0.
module idelay_eye_tracker
   import rgmii_idelay_pkg::*;
#(
   parameter int TAP_BITS = rgmii_idelay_pkg::TAP_BITS
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                clear_i,
   input  logic                eval_i,
   input  logic                pass_i,
   input  logic [TAP_BITS-1:0] tap_i,
   output logic [TAP_BITS-1:0] bestStart_o,
   output logic [TAP_BITS:0]   bestLength_o
);

   logic [TAP_BITS-1:0] curStart_q, curStart_d;
   logic [TAP_BITS:0]   curLen_q, curLen_d;
   logic [TAP_BITS-1:0] bestStart_q, bestStart_d;
   logic [TAP_BITS:0]   bestLength_q, bestLength_d;
   logic [TAP_BITS-1:0] runStart;
   logic [TAP_BITS:0]   runLen;

   // Extend or break the current run on each verdict; a strictly longer
   // run replaces the best one so ties keep the earliest.
   always_comb begin
      curStart_d   = curStart_q;
      curLen_d     = curLen_q;
      bestStart_d  = bestStart_q;
      bestLength_d = bestLength_q;
      runStart     = (curLen_q == '0) ? tap_i : curStart_q;
      runLen       = curLen_q + (TAP_BITS+1)'(1);
      if (clear_i) begin
         curStart_d   = '0;
         curLen_d     = '0;
         bestStart_d  = '0;
         bestLength_d = '0;
      end else if (eval_i) begin
         if (pass_i) begin
            curStart_d = runStart;
            curLen_d   = runLen;
            if (runLen > bestLength_q) begin
               bestStart_d  = runStart;
               bestLength_d = runLen;
            end
         end else begin
            curLen_d = '0;
         end
      end
   end

   // Run and best-run registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         curStart_q   <= '0;
         curLen_q     <= '0;
         bestStart_q  <= '0;
         bestLength_q <= '0;
      end else begin
         curStart_q   <= curStart_d;
         curLen_q     <= curLen_d;
         bestStart_q  <= bestStart_d;
         bestLength_q <= bestLength_d;
      end
   end

   assign bestStart_o  = bestStart_q;
   assign bestLength_o = bestLength_q;

endmodule

// File: rtl/rgmii_idelay_calibrator.sv
// RGMII receive IDELAY calibrator. Once IDELAYCTRL is ready it steps the
// shared RXD/RX_CTL tap through every value, lets each tap settle, scores
// a measurement window of good/bad RX pulses, then loads the centre of the
// longest passing run (or the default tap if nothing passed).
module rgmii_idelay_calibrator
   import rgmii_idelay_pkg::*;
#(
   parameter int TAP_BITS      = rgmii_idelay_pkg::TAP_BITS,
   parameter int SETTLE_CYCLES = 64,
   parameter int WINDOW_CYCLES = 65536,
   parameter int MIN_GOOD      = 4,
   parameter int DEFAULT_TAP   = 13
) (
   input logic clock,
   input logic reset,
   rgmii_idelay_calibrator_if.master bus
);

   localparam int MAX_PHASE = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
   localparam int CNT_W     = $clog2(MAX_PHASE + 1);
   localparam int GOOD_W    = 16;
   localparam logic [TAP_BITS-1:0] TAP_MAX = {TAP_BITS{1'b1}};

   calState_t           state_q, state_d;
   logic [TAP_BITS-1:0] tap_q, tap_d;
   logic                fail_q, fail_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [GOOD_W-1:0]   goodCount_q, goodCount_d;
   logic                badSeen_q, badSeen_d;

   logic                tapLoad;
   logic [TAP_BITS-1:0] tapOut;
   logic                trackClear;
   logic                trackEval;
   logic                tapPass;
   logic [TAP_BITS-1:0] bestStart;
   logic [TAP_BITS:0]   bestLength;
   logic [TAP_BITS-1:0] centre;

   assign tapPass = !badSeen_q && (goodCount_q >= GOOD_W'(MIN_GOOD));
   assign centre  = TAP_BITS'(centreTap(32'(bestStart), 32'(bestLength)));

   // Sequencer: next state, tap/score updates and the LD strobe. Losing
   // IDELAYCTRL ready mid-sweep abandons the sweep without touching the tap.
   always_comb begin
      state_d     = state_q;
      tap_d       = tap_q;
      fail_d      = fail_q;
      cnt_d       = cnt_q;
      goodCount_d = goodCount_q;
      badSeen_d   = badSeen_q;
      tapLoad     = 1'b0;
      tapOut      = tap_q;
      trackClear  = 1'b0;
      trackEval   = 1'b0;
      case (state_q)
         WAIT_RDY: begin
            if (bus.io_idelayctrl_ready) begin
               state_d     = LOAD;
               tap_d       = '0;
               fail_d      = 1'b0;
               cnt_d       = '0;
               goodCount_d = '0;
               badSeen_d   = 1'b0;
               trackClear  = 1'b1;
            end
         end
         DONE: begin
            if (bus.io_start) begin
               state_d = WAIT_RDY;
            end
         end
         default: begin
            if (!bus.io_idelayctrl_ready) begin
               state_d = WAIT_RDY;
            end else begin
               case (state_q)
                  LOAD: begin
                     tapLoad = 1'b1;
                     cnt_d   = '0;
                     state_d = SETTLE;
                  end
                  SETTLE: begin
                     if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                        cnt_d   = '0;
                        state_d = MEASURE;
                     end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                     end
                  end
                  MEASURE: begin
                     if (bus.io_good && (goodCount_q != '1)) begin
                        goodCount_d = goodCount_q + GOOD_W'(1);
                     end
                     if (bus.io_bad) begin
                        badSeen_d = 1'b1;
                     end
                     if (cnt_q == CNT_W'(WINDOW_CYCLES - 1)) begin
                        cnt_d   = '0;
                        state_d = EVAL;
                     end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                     end
                  end
                  EVAL: begin
                     trackEval   = 1'b1;
                     goodCount_d = '0;
                     badSeen_d   = 1'b0;
                     if (tap_q == TAP_MAX) begin
                        state_d = APPLY;
                     end else begin
                        tap_d   = tap_q + TAP_BITS'(1);
                        state_d = LOAD;
                     end
                  end
                  APPLY: begin
                     tapLoad = 1'b1;
                     if (bestLength == '0) begin
                        tap_d  = TAP_BITS'(DEFAULT_TAP);
                        fail_d = 1'b1;
                     end else begin
                        tap_d = centre;
                     end
                     tapOut  = tap_d;
                     state_d = DONE;
                  end
                  default: begin
                     state_d = WAIT_RDY;
                  end
               endcase
            end
         end
      endcase
   end

   // Sequencer registers; reset parks the tap at the default value.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= WAIT_RDY;
         tap_q       <= TAP_BITS'(DEFAULT_TAP);
         fail_q      <= 1'b0;
         cnt_q       <= '0;
         goodCount_q <= '0;
         badSeen_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         tap_q       <= tap_d;
         fail_q      <= fail_d;
         cnt_q       <= cnt_d;
         goodCount_q <= goodCount_d;
         badSeen_q   <= badSeen_d;
      end
   end

   idelay_eye_tracker #(
      .TAP_BITS (TAP_BITS)
   ) eyeTracker (
      .clock        (clock),
      .reset        (reset),
      .clear_i      (trackClear),
      .eval_i       (trackEval),
      .pass_i       (tapPass),
      .tap_i        (tap_q),
      .bestStart_o  (bestStart),
      .bestLength_o (bestLength)
   );

   assign bus.io_tap_value   = tapOut;
   assign bus.io_tap_load    = tapLoad;
   assign bus.io_busy        = (state_q != WAIT_RDY) && (state_q != DONE);
   assign bus.io_done        = (state_q == DONE);
   assign bus.io_fail        = fail_q;
   assign bus.io_best_start  = bestStart;
   assign bus.io_best_length = bestLength;

endmodule

// File: doc/rgmii_idelay_calibrator.md
Name: rgmii_idelay_calibrator

Overview:
Sequences the five RGMII receive IDELAYE2 elements (RXD[3:0] and RX_CTL, which share one tap value) in VAR_LOAD mode. After IDELAYCTRL reports ready, it sweeps taps 0..31, settles, then scores receive quality from pulses produced by the Ethernet RX path. It then loads the centre of the longest passing tap run. It sits in the top-level beside the IDELAYCTRL, clocked by the IDELAY C-port clock.

Parameters:
TAP_BITS, 5, tap width; the sweep covers 0..2^TAP_BITS-1.
SETTLE_CYCLES, 64, cycles ignored after each tap load.
WINDOW_CYCLES, 65536, measurement window per tap.
MIN_GOOD, 4, minimum io_good pulses in a window for a tap to pass.
DEFAULT_TAP, 13, tap applied at reset and on calibration failure.

Ports:
clock  in  1  single clock; also drives the IDELAYE2 C pins.
reset  in  1  synchronous, active-high.
io_idelayctrl_ready  in  1  IDELAYCTRL RDY, already synchronised to clock.
io_start  in  1  single-cycle pulse; reruns calibration from the DONE state.
io_good  in  1  pulse per good RX event (valid preamble/SFD or CRC-ok frame), synchronous to clock.
io_bad  in  1  pulse per RX error (CRC fail or RX_CTL error), synchronous to clock.
io_tap_value  out  TAP_BITS  drives IDELAYE2 CNTVALUEIN.
io_tap_load  out  1  drives IDELAYE2 LD; one-cycle pulse.
io_busy  out  1  sweep in progress.
io_done  out  1  calibration finished.
io_fail  out  1  no passing tap found.
io_best_start  out  TAP_BITS  first tap of the chosen run.
io_best_length  out  TAP_BITS+1  length of the chosen run.

Behaviour:
- Reset values: io_tap_value=DEFAULT_TAP; io_tap_load, io_busy, io_done and io_fail =0; io_best_start=0; io_best_length=0; state WAIT_RDY.
- A reset in any state restores all reset values on the next edge. Any partial sweep is discarded.
- WAIT_RDY: on a cycle with ready=1, go to LOAD. Set tap=0, busy=1, done=0, fail=0, clear the current-run and best-run trackers.
- LOAD: io_tap_value=tap and io_tap_load=1 for exactly this cycle, then go to SETTLE.
- io_tap_value is held stable at all times except when the state machine updates it.
- SETTLE: lasts SETTLE_CYCLES cycles. io_good and io_bad are ignored.
- MEASURE: lasts WINDOW_CYCLES cycles.
  - Count io_good with a saturating counter of 16 bits minimum.
  - io_bad sets a sticky bad_seen flag.
  - Only cycles spent in MEASURE are counted.
- EVAL (1 cycle):
  - pass = (bad_seen==0) && (good_count>=MIN_GOOD).
  - On pass: if cur_len==0 then cur_start=tap; increment cur_len. If the new cur_len > best_length (strict), copy the current run to best. Ties therefore keep the earliest run.
  - On fail: cur_len=0.
  - Clear good_count and bad_seen.
  - If tap==max, go to APPLY; else tap+1, go to LOAD.
  - There is no wrap-around: runs never join across max→0. A run ending at tap max is captured by the per-EVAL update.
- Per-tap duration is SETTLE_CYCLES+WINDOW_CYCLES+2 cycles.
- APPLY (1 cycle):
  - If best_length==0: tap=DEFAULT_TAP, fail=1.
  - Else: tap = best_start + ((best_length-1)>>1), i.e. floor of the centre.
  - io_tap_load=1 this cycle, then go to DONE.
- DONE: done=1, busy=0. io_best_start and io_best_length hold their values. An io_start pulse goes to WAIT_RDY-equivalent entry, i.e. a restart from tap 0 once ready=1.
- io_start is ignored outside DONE.
- If io_idelayctrl_ready falls in LOAD, SETTLE, MEASURE, EVAL or APPLY:
  - go to WAIT_RDY with busy=0 and no further loads;
  - io_tap_value keeps its last value;
  - the sweep restarts from tap 0 when ready returns.
- If ready falls in DONE, the block stays in DONE.
- io_best_start and io_best_length update only in EVAL or on a sweep start, and are valid when done=1.

Decomposition:
- Shared package (rgmii_idelay_pkg) holds:
  - the TAP_BITS constant;
  - the state enum (WAIT_RDY, LOAD, SETTLE, MEASURE, EVAL, APPLY, DONE);
  - the centre-tap function.
- One natural sub-module, idelay_eye_tracker. Inputs: eval strobe, pass, tap, clear. Outputs: best_start and best_length. It contains the longest-run logic and is reused for future TX-delay tuning.

Test Plan:
Parameters for all scenarios: SETTLE_CYCLES=4, WINDOW_CYCLES=32, MIN_GOOD=2, DEFAULT_TAP=13.
1. Hold ready=0 for 100 cycles → no io_tap_load, tap=13, busy=0. Raise ready → load pulse with tap=0 on the next cycle, busy=1, then loads every 38 cycles.
2. io_good every 4 cycles only while tap in 10..20, io_bad never → done=1, fail=0, best_start=10, best_length=11, final load with tap=15.
3. Passing runs 2..5 and 20..23 → best_start=2, best_length=4, tap=3 (tie keeps earliest). Passing runs 2..5 and 25..31 → best_start=25, best_length=7, tap=28.
4. Good at taps 10..20 but one io_bad during MEASURE at tap 15 → best_start=10, best_length=5, tap=12. Also: one io_good per window only → fail=1, tap=13, load pulsed, done=1.
5. Drop ready during MEASURE at tap 7 → busy=0, no loads, tap stays 7. Restore ready → restart with load tap=0. Assert reset mid-SETTLE → all outputs return to reset values next cycle.
6. io_start while busy → ignored (sweep unaffected). io_start in DONE → done=0, busy=1, load tap=0; the rerun with the same stimulus reproduces identical results.
